// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and slice width.
// Optional overflow output is enabled by the SERIAL_ADDER_OVF_EN macro in the top.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a single-nibble build still needs a 1-bit counter.
    function automatic int idxWidth(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// The existing 4-bit ripple adder stage, purely combinational.
module adder_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder feeding one nibble per clock through a single adder_4bits.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output o_ovf.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [4*NIBBLES-1:0]    i_a,
    input  logic [4*NIBBLES-1:0]    i_b,
    input  logic                    i_ci,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NIBBLES-1:0]    o_s,
    output logic                    o_co
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                    o_ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idxWidth(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                r_state;
    logic [W-1:0]          r_opA;
    logic [W-1:0]          r_opB;
    logic                  r_carry;
    logic [IDX_W-1:0]      r_idx;
    logic [W-1:0]          r_s;
    logic                  r_co;
    logic                  r_busy;
    logic                  r_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic                  r_ovf;
`endif

    logic [NIBBLE_W-1:0]   w_sliceA;
    logic [NIBBLE_W-1:0]   w_sliceB;
    logic [NIBBLE_W-1:0]   w_sum;
    logic                  w_co;

    // Select the current nibble of each latched operand for the shared adder.
    always_comb begin
        w_sliceA = '0;
        w_sliceB = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_sliceA = r_opA[n*NIBBLE_W +: NIBBLE_W];
                w_sliceB = r_opB[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    adder_4bits u_adder (
        .a  (w_sliceA),
        .b  (w_sliceB),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_opA   <= i_a;
                        r_opB   <= i_b;
                        r_carry <= i_ci;
                        r_idx   <= '0;
                        r_s     <= '0;
                        r_co    <= 1'b0;
                        r_busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int n = 0; n < NIBBLES; n++) begin
                        if (r_idx == IDX_W'(n)) begin
                            r_s[n*NIBBLE_W +: NIBBLE_W] <= w_sum;
                        end
                    end
                    r_carry <= w_co;
                    if (r_idx == LAST_IDX) begin
                        // Final slice: the carry out of this nibble is the result carry.
                        r_idx   <= '0;
                        r_co    <= w_co;
                        r_done  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        r_ovf   <= r_opA[W-1] ^ r_opB[W-1] ^ w_sum[NIBBLE_W-1] ^ w_co;
`endif
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_s    = r_s;
    assign o_co   = r_co;
`ifdef SERIAL_ADDER_OVF_EN
    assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4) against an arithmetic reference model.
// Covers handshake timing, carry propagation, start masking, back-to-back starts and async reset.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [W-1:0]  i_a;
    logic [W-1:0]  i_b;
    logic          i_ci;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_s;
    logic          o_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic          o_ovf;
`endif

    int nChecks = 0;
    int nFail   = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_ci    (i_ci),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_s     (o_s),
        .o_co    (o_co)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned W+1 bit sum, and signed-range overflow of a+b+ci.
    function automatic logic [W:0] refSum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic refOvf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int sa, sb, tot;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        tot = sa + sb + int'(ci);
        return (tot > 32767) || (tot < -32768);
    endfunction

    // Runs one full operation; optionally re-pulses start with other operands during RUN.
    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input bit repulse);
        logic [W:0] expSum;
        int busyCycles;
        expSum = refSum(a, b, ci);
        busyCycles = 0;
        @(negedge clk);
        i_a = a; i_b = b; i_ci = ci; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        i_a = W'($urandom); i_b = W'($urandom); i_ci = 1'($urandom);
        checkOutput({tag, ".busyE0"}, 32'(o_busy), 32'd1);
        checkOutput({tag, ".doneE0"}, 32'(o_done), 32'd0);
        if (o_busy) busyCycles++;
        for (int k = 1; k <= N + 1; k++) begin
            if (repulse && k == 2) begin
                i_start = 1'b1;
                i_a = W'($urandom); i_b = W'($urandom); i_ci = 1'($urandom);
            end
            if (repulse && k == 4) i_start = 1'b0;
            @(negedge clk);
            if (o_busy) busyCycles++;
            if (k < N) begin
                checkOutput($sformatf("%s.doneLowE%0d", tag, k), 32'(o_done), 32'd0);
            end else if (k == N) begin
                checkOutput({tag, ".donePulse"}, 32'(o_done), 32'd1);
                checkOutput({tag, ".busyAtDone"}, 32'(o_busy), 32'd1);
                checkOutput({tag, ".sum"}, 32'(o_s), 32'(expSum[W-1:0]));
                checkOutput({tag, ".co"}, 32'(o_co), 32'(expSum[W]));
`ifdef SERIAL_ADDER_OVF_EN
                checkOutput({tag, ".ovf"}, 32'(o_ovf), 32'(refOvf(a, b, ci)));
`endif
            end else begin
                checkOutput({tag, ".doneEnd"}, 32'(o_done), 32'd0);
                checkOutput({tag, ".busyEnd"}, 32'(o_busy), 32'd0);
                checkOutput({tag, ".sumHeld"}, 32'(o_s), 32'(expSum[W-1:0]));
            end
        end
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(N + 1));
    endtask

    initial begin
        logic [W:0] expSum;
        logic [W-1:0] ra, rb;
        logic rc;

        rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_ci = 1'b0;
        #12;
        checkOutput("reset.busy", 32'(o_busy), 32'd0);
        checkOutput("reset.done", 32'(o_done), 32'd0);
        checkOutput("reset.s", 32'(o_s), 32'd0);
        checkOutput("reset.co", 32'(o_co), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("reset.ovf", 32'(o_ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("basic", 16'h0001, 16'h0002, 1'b0, 1'b0);
        applyStimulus("nibCarry", 16'h000F, 16'h0001, 1'b0, 1'b0);
        applyStimulus("allCarry", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        applyStimulus("sgnOvf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        applyStimulus("negOvf", 16'h8000, 16'h8000, 1'b0, 1'b0);
        applyStimulus("repulse", 16'h1234, 16'h4321, 1'b1, 1'b1);

        for (int r = 0; r < 16; r++) begin
            applyStimulus($sformatf("rand%0d", r), W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Start held high straight through DONE is taken again from IDLE.
        @(negedge clk);
        i_a = 16'h0F0F; i_b = 16'h00F1; i_ci = 1'b0; i_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < N; k++) @(posedge clk);
        @(negedge clk);
        checkOutput("b2b.firstDone", 32'(o_done), 32'd1);
        i_a = 16'hA5A5; i_b = 16'h5A5B; i_ci = 1'b1;
        @(negedge clk);
        checkOutput("b2b.idleGap", 32'(o_busy), 32'd0);
        @(negedge clk);
        checkOutput("b2b.reaccept", 32'(o_busy), 32'd1);
        i_start = 1'b0;
        expSum = refSum(16'hA5A5, 16'h5A5B, 1'b1);
        for (int k = 0; k < N; k++) @(negedge clk);
        checkOutput("b2b.done", 32'(o_done), 32'd1);
        checkOutput("b2b.sum", 32'(o_s), 32'(expSum[W-1:0]));
        checkOutput("b2b.co", 32'(o_co), 32'(expSum[W]));
        @(negedge clk);

        // Abort in the third RUN cycle; partial sum slices are nonzero by then.
        ra = 16'hFF77; rb = 16'h0011; rc = 1'b1;
        @(negedge clk);
        i_a = ra; i_b = rb; i_ci = rc; i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort.partialBusy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(o_busy), 32'd0);
        checkOutput("abort.done", 32'(o_done), 32'd0);
        checkOutput("abort.s", 32'(o_s), 32'd0);
        checkOutput("abort.co", 32'(o_co), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * N + 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("abort.noDone%0d", k), 32'(o_done | o_busy), 32'd0);
        end

        applyStimulus("postAbort", 16'h7FFF, 16'h0001, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
